sw_sram_port_arbiter: RTL and testbench
=======================================

// Module: sw_sram_port_arbiter
// PURPOSE
//   Shares the single SRAM read port (sel_T/addr/data) between the target
//   fetcher (T) and the query fetcher (Q) of the SmithWaterman core.
//   Grants are burst-oriented with round-robin hand-over and a starvation
//   cap. Each returned word is routed back to the requester that issued it.
//   Sits between the two fetch engines and the SRAM pins of the top level.
// PARAMETERS
//   ADDR_W     10  SRAM address width (matches SRAM_ADDR_BIT)
//   DATA_W     32  SRAM word width (matches SRAM_WORD_WIDTH)
//   RD_LAT     1   cycles from address issue to sram_data_i valid (1..4)
//   BURST_MAX  16  max consecutive grants to one owner while the other waits
// PORTS
//   clk          in   1       clock, all state on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   t_req_i      in   1       T fetcher requests a read this cycle
//   t_addr_i     in   ADDR_W  T read address
//   t_last_i     in   1       current T request ends its burst
//   t_gnt_o      out  1       T request accepted this cycle
//   t_rvalid_o   out  1       rdata_o belongs to T this cycle
//   q_req_i      in   1       Q fetcher requests a read this cycle
//   q_addr_i     in   ADDR_W  Q read address
//   q_last_i     in   1       current Q request ends its burst
//   q_gnt_o      out  1       Q request accepted this cycle
//   q_rvalid_o   out  1       rdata_o belongs to Q this cycle
//   rdata_o      out  DATA_W  returned word (pass-through of sram_data_i)
//   sram_sel_T_o out  1       1 = target memory, 0 = query memory
//   sram_addr_o  out  ADDR_W  SRAM address
//   sram_data_i  in   DATA_W  SRAM read data
//   busy_o       out  1       owner held or any read in flight
// BEHAVIOUR
//   Reset: state=IDLE, last_owner=T (so Q wins first tie), burst_cnt=0,
//     tag pipe cleared; gnt/rvalid/busy=0, sram_sel_T_o=0, sram_addr_o=0.
//   States: IDLE, OWN_T, OWN_Q.
//   IDLE: only one req -> grant it same cycle, go OWN_x. Both req -> grant
//     the one != last_owner. No req -> stay, SRAM outputs hold last value.
//   OWN_x: x_gnt_o = x_req_i (combinational). Leave to IDLE-equivalent
//     arbitration at next edge when: x_req_i=0, or x_req_i&x_last_i granted,
//     or burst_cnt==BURST_MAX-1 granted while other req=1 (forced release).
//     On leaving, last_owner<=x; if other req is high, next state OWN_other
//     directly (no idle bubble). Never both gnt in one cycle.
//   burst_cnt: clears on ownership change, +1 per grant, saturates at
//     BURST_MAX-1; cap only enforced when other requester is waiting.
//   SRAM mux: sram_sel_T_o/sram_addr_o follow the granted requester
//     combinationally in the grant cycle; otherwise hold previous values.
//   Return path: RD_LAT-deep shift register of {valid,is_T}; grant in
//     cycle n -> x_rvalid_o=1 in cycle n+RD_LAT, rdata_o=sram_data_i.
//     Tags survive ownership changes; back-to-back grants give
//     back-to-back rvalids, in order.
//   busy_o = (state!=IDLE) | any tag valid.
//   Reset mid-burst: all in-flight tags dropped, no rvalid afterwards.
//   x_last_i without x_req_i is ignored.
// TESTING
//   1 Reset, q_req 4 cycles addr 0..3, last on 3 -> q_gnt 4 cycles, q_rvalid
//     cycles 2..5 (RD_LAT=1) with Q_mem[0..3], sram_sel_T_o=0, t_rvalid=0.
//   2 t_req and q_req asserted together from IDLE after reset -> Q granted
//     first; after Q last, T granted next cycle with no bubble.
//   3 T streams 40 reads with no last while q_req held -> T gets exactly 16
//     grants, Q granted cycle 17, T resumes after Q's burst ends.
//   4 Owner switches T->Q with RD_LAT=3 -> 3 T rvalids then Q rvalids,
//     data matches issuing memory, no cycle with both rvalids high.
//   5 Assert rst_n=0 with 2 reads in flight -> all outputs 0 immediately,
//     no rvalid after release, busy_o=0.
//   6 q_last_i pulsed without q_req_i -> no grant, state stays IDLE.

Source files
------------

// File: rtl/sw_sram_port_arbiter.sv
// sw_sram_port_arbiter: burst round-robin share of one SRAM read port
// between the T and Q fetchers, with tagged routing of returned words.
module sw_sram_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              t_req_i,
  input  logic [ADDR_W-1:0] t_addr_i,
  input  logic              t_last_i,
  output logic              t_gnt_o,
  output logic              t_rvalid_o,
  input  logic              q_req_i,
  input  logic [ADDR_W-1:0] q_addr_i,
  input  logic              q_last_i,
  output logic              q_gnt_o,
  output logic              q_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sram_sel_T_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              busy_o
);

  localparam int CNT_W =
    (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CAP =
    CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_T = 2'd1,
    OWN_Q = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_t;
  logic              last_t_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              t_gnt;
  logic              q_gnt;
  logic              gnt;
  logic              x_act;
  logic              x_is_t;
  logic              x_req;
  logic              x_last;
  logic              o_req;
  logic              rel;
  logic              hold_sel;
  logic [ADDR_W-1:0] hold_addr;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_t;

  // pick the requester that owns the port this cycle
  always_comb begin
    t_gnt = 1'b0;
    q_gnt = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        state == OWN_T: t_gnt = t_req_i;
        state == OWN_Q: q_gnt = q_req_i;
        default: begin
          t_gnt = t_req_i & ~(q_req_i & last_t);
          q_gnt = q_req_i & ~(t_req_i & ~last_t);
        end
      endcase
    end
  end

  assign gnt = t_gnt | q_gnt;

  // burst bookkeeping: release on idle, last or cap, hand over
  always_comb begin
    state_nxt  = state;
    last_t_nxt = last_t;
    cnt_nxt    = cnt;
    x_act  = (state != IDLE) | gnt;
    x_is_t = (state == OWN_T) |
             ((state == IDLE) & t_gnt);
    x_req  = x_is_t ? t_req_i  : q_req_i;
    x_last = x_is_t ? t_last_i : q_last_i;
    o_req  = x_is_t ? q_req_i  : t_req_i;
    rel    = ~x_req |
             (gnt & x_last) |
             (gnt & (cnt == CAP) & o_req);
    if (x_act) begin
      if (rel) begin
        last_t_nxt = x_is_t;
        cnt_nxt    = '0;
        if (o_req) begin
          state_nxt = x_is_t ? OWN_Q : OWN_T;
        end else begin
          state_nxt = IDLE;
        end
      end else begin
        state_nxt = x_is_t ? OWN_T : OWN_Q;
        if (cnt != CAP) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    end
  end

  // owner state, tie-break memory and burst length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_t <= 1'b1;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      last_t <= last_t_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // SRAM pins keep the last granted selection between grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_sel  <= 1'b0;
      hold_addr <= '0;
    end else if (gnt) begin
      hold_sel  <= t_gnt;
      hold_addr <= t_gnt ? t_addr_i : q_addr_i;
    end
  end

  // return tags travel with the read through the SRAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_t   <= '0;
    end else begin
      tag_vld[0] <= gnt;
      tag_t[0]   <= t_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_t[i]   <= tag_t[i-1];
      end
    end
  end

  assign t_gnt_o      = t_gnt;
  assign q_gnt_o      = q_gnt;
  assign sram_sel_T_o = gnt ? t_gnt : hold_sel;
  assign sram_addr_o  = t_gnt ? t_addr_i :
                        q_gnt ? q_addr_i : hold_addr;
  assign t_rvalid_o   = tag_vld[RD_LAT-1] &
                        tag_t[RD_LAT-1];
  assign q_rvalid_o   = tag_vld[RD_LAT-1] &
                        ~tag_t[RD_LAT-1];
  assign rdata_o      = sram_data_i;
  assign busy_o       = (state != IDLE) | (|tag_vld);

endmodule

// File: tb/tb_sw_sram_port_arbiter.sv
// tb_sw_sram_port_arbiter: table vectors, corner sequences and random
// traffic against a grant-log reference, at read latencies 1 and 3.
`timescale 1ns/1ps
module tb_sw_sram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BM = 16;
  localparam int NC = 4096;

  typedef struct {
    bit rs;
    bit tr; logic [AW-1:0] ta; bit tl;
    bit qr; logic [AW-1:0] qa; bit ql;
    bit ck;
    bit etg; bit eqg; bit etrv; bit eqrv;
    bit esel; logic [AW-1:0] ea; bit eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic t_req = 1'b0, t_last = 1'b0;
  logic q_req = 1'b0, q_last = 1'b0;
  logic [AW-1:0] t_addr = '0, q_addr = '0;

  logic t_gnt1, q_gnt1, t_rv1, q_rv1, sel1, busy1;
  logic [AW-1:0] saddr1;
  logic [DW-1:0] rdata1, sdata1;
  logic t_gnt3, q_gnt3, t_rv3, q_rv3, sel3, busy3;
  logic [AW-1:0] saddr3;
  logic [DW-1:0] rdata3, sdata3;

  always #5 clk = ~clk;

  sw_sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW),
    .RD_LAT(1), .BURST_MAX(BM)) u1 (
    .clk(clk), .rst_n(rst_n),
    .t_req_i(t_req), .t_addr_i(t_addr), .t_last_i(t_last),
    .t_gnt_o(t_gnt1), .t_rvalid_o(t_rv1),
    .q_req_i(q_req), .q_addr_i(q_addr), .q_last_i(q_last),
    .q_gnt_o(q_gnt1), .q_rvalid_o(q_rv1),
    .rdata_o(rdata1), .sram_sel_T_o(sel1),
    .sram_addr_o(saddr1), .sram_data_i(sdata1),
    .busy_o(busy1));

  sw_sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW),
    .RD_LAT(3), .BURST_MAX(BM)) u3 (
    .clk(clk), .rst_n(rst_n),
    .t_req_i(t_req), .t_addr_i(t_addr), .t_last_i(t_last),
    .t_gnt_o(t_gnt3), .t_rvalid_o(t_rv3),
    .q_req_i(q_req), .q_addr_i(q_addr), .q_last_i(q_last),
    .q_gnt_o(q_gnt3), .q_rvalid_o(q_rv3),
    .rdata_o(rdata3), .sram_sel_T_o(sel3),
    .sram_addr_o(saddr3), .sram_data_i(sdata3),
    .busy_o(busy3));

  function automatic logic [DW-1:0] mem_word(
    input bit is_t, input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = {16'h5151, 6'd0, a};
    if (is_t) w = {16'hA7A7, 6'd0, a};
    return w;
  endfunction

  // synchronous SRAMs: address sampled each edge, data RD_LAT later
  logic [AW:0] p1;
  logic [AW:0] p3 [3];
  always @(posedge clk) begin
    p1 <= {sel1, saddr1};
    p3[0] <= {sel3, saddr3};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign sdata1 = mem_word(p1[AW], p1[AW-1:0]);
  assign sdata3 = mem_word(p3[2][AW], p3[2][AW-1:0]);

  // reference: owner 0 none, 1 T, 2 Q; grants logged per cycle
  int owner = 0;
  bit mlast_t = 1'b1;
  int burst = 0;
  bit hsel = 1'b0;
  logic [AW-1:0] haddr = '0;
  int eg;
  bit esel;
  logic [AW-1:0] eaddr;
  int glog [NC];
  logic [AW-1:0] alog [NC];
  int cyc = 0;
  int valid_from = 0;
  int nvec = 0;
  int nbad = 0;
  bit obs_tg, obs_qg, obs_trv3, obs_qrv3;

  task automatic chk(input string n,
    input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      if (nbad <= 40)
        $display("FAIL %s cyc=%0d got %0h want %0h",
          n, cyc, act, exp);
    end
  endtask

  function automatic int ret(input int lat);
    int idx;
    idx = cyc - lat;
    if (idx < valid_from) return 0;
    return glog[idx];
  endfunction

  task automatic chk_inst(input string n, input int lat,
    input logic tg, input logic qg,
    input logic trv, input logic qrv, input logic sel,
    input logic [AW-1:0] ad, input logic [DW-1:0] rd,
    input logic bz);
    int r;
    bit eb;
    r = ret(lat);
    eb = (owner != 0);
    for (int k = 1; k <= lat; k++)
      if (ret(k) != 0) eb = 1'b1;
    chk({n, "_t_gnt"}, tg, eg == 1);
    chk({n, "_q_gnt"}, qg, eg == 2);
    chk({n, "_sel"}, sel, esel);
    chk({n, "_addr"}, ad, eaddr);
    chk({n, "_t_rvalid"}, trv, r == 1);
    chk({n, "_q_rvalid"}, qrv, r == 2);
    chk({n, "_excl"}, trv & qrv, 0);
    if (r != 0)
      chk({n, "_rdata"}, rd, mem_word(r == 1, alog[cyc - lat]));
    chk({n, "_busy"}, bz, eb);
  endtask

  task automatic step(input vec_t v);
    int x, cur;
    bit xr, xl, orq;
    t_req = v.tr; t_addr = v.ta; t_last = v.tl;
    q_req = v.qr; q_addr = v.qa; q_last = v.ql;
    @(negedge clk);
    if (owner == 1) eg = t_req ? 1 : 0;
    else if (owner == 2) eg = q_req ? 2 : 0;
    else if (t_req && q_req) eg = mlast_t ? 2 : 1;
    else if (t_req) eg = 1;
    else if (q_req) eg = 2;
    else eg = 0;
    esel = (eg == 0) ? hsel : (eg == 1);
    eaddr = (eg == 1) ? t_addr : (eg == 2) ? q_addr : haddr;
    chk_inst("l1", 1, t_gnt1, q_gnt1, t_rv1, q_rv1, sel1,
      saddr1, rdata1, busy1);
    chk_inst("l3", 3, t_gnt3, q_gnt3, t_rv3, q_rv3, sel3,
      saddr3, rdata3, busy3);
    if (v.ck) begin
      chk("tbl_t_gnt", t_gnt1, v.etg);
      chk("tbl_q_gnt", q_gnt1, v.eqg);
      chk("tbl_t_rvalid", t_rv1, v.etrv);
      chk("tbl_q_rvalid", q_rv1, v.eqrv);
      chk("tbl_sel", sel1, v.esel);
      chk("tbl_addr", saddr1, v.ea);
      chk("tbl_busy", busy1, v.eb);
    end
    obs_tg = t_gnt1; obs_qg = q_gnt1;
    obs_trv3 = t_rv3; obs_qrv3 = q_rv3;
    @(posedge clk);
    glog[cyc] = eg;
    alog[cyc] = eaddr;
    if (eg != 0) begin hsel = esel; haddr = eaddr; end
    x = (owner != 0) ? owner : eg;
    if (x != 0) begin
      xr  = (x == 1) ? t_req : q_req;
      xl  = (x == 1) ? t_last : q_last;
      orq = (x == 1) ? q_req : t_req;
      cur = (owner == 0) ? 0 : burst;
      if (!xr || (eg != 0 && xl) ||
          (eg != 0 && cur == BM - 1 && orq)) begin
        mlast_t = (x == 1);
        burst = 0;
        owner = orq ? 3 - x : 0;
      end else begin
        owner = x;
        burst = (cur + 1 > BM - 1) ? BM - 1 : cur + 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input bit keep_req);
    t_req = keep_req; q_req = keep_req;
    t_last = 1'b0; q_last = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_t_gnt", {t_gnt1, t_gnt3}, 0);
    chk("rst_q_gnt", {q_gnt1, q_gnt3}, 0);
    chk("rst_rvalid", {t_rv1, q_rv1, t_rv3, q_rv3}, 0);
    chk("rst_busy", {busy1, busy3}, 0);
    chk("rst_sel", {sel1, sel3}, 0);
    chk("rst_addr", {saddr1, saddr3}, 0);
    t_req = 1'b0; q_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    owner = 0; mlast_t = 1'b1; burst = 0;
    hsel = 1'b0; haddr = '0;
    valid_from = cyc;
  endtask

  function automatic vec_t mkv(input bit rs,
    input bit tr, input int ta, input bit tl,
    input bit qr, input int qa, input bit ql,
    input bit etg, input bit eqg, input bit etrv,
    input bit eqrv, input bit es, input int ea, input bit eb);
    vec_t v;
    v.rs = rs; v.ck = 1'b1;
    v.tr = tr; v.ta = AW'(ta); v.tl = tl;
    v.qr = qr; v.qa = AW'(qa); v.ql = ql;
    v.etg = etg; v.eqg = eqg; v.etrv = etrv; v.eqrv = eqrv;
    v.esel = es; v.ea = AW'(ea); v.eb = eb;
    return v;
  endfunction

  function automatic vec_t mks(input bit tr, input int ta,
    input bit tl, input bit qr, input int qa, input bit ql);
    vec_t v;
    v = mkv(0, tr, ta, tl, qr, qa, ql, 0, 0, 0, 0, 0, 0, 0);
    v.ck = 1'b0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int tg, qg, first_q, t_before, t_resume;
    int tgc, qgc, first_trv, first_qrv;
    int seq3[$];

    // Q-only burst of 4, latency 1
    tbl.push_back(mkv(1, 0,0,0, 1,0,0, 0,1,0,0,0,0,0));
    tbl.push_back(mkv(0, 0,0,0, 1,1,0, 0,1,0,1,0,1,1));
    tbl.push_back(mkv(0, 0,0,0, 1,2,0, 0,1,0,1,0,2,1));
    tbl.push_back(mkv(0, 0,0,0, 1,3,1, 0,1,0,1,0,3,1));
    tbl.push_back(mkv(0, 0,0,0, 0,0,0, 0,0,0,1,0,3,1));
    tbl.push_back(mkv(0, 0,0,0, 0,0,0, 0,0,0,0,0,3,0));
    // simultaneous request: Q first, T without bubble
    tbl.push_back(mkv(1, 1,'h10,0, 1,'h20,0, 0,1,0,0,0,'h20,0));
    tbl.push_back(mkv(0, 1,'h10,0, 1,'h21,1, 0,1,0,1,0,'h21,1));
    tbl.push_back(mkv(0, 1,'h10,0, 0,0,0, 1,0,0,1,1,'h10,1));
    tbl.push_back(mkv(0, 1,'h11,1, 0,0,0, 1,0,1,0,1,'h11,1));
    tbl.push_back(mkv(0, 0,0,0, 0,0,0, 0,0,1,0,1,'h11,1));
    tbl.push_back(mkv(0, 0,0,0, 0,0,0, 0,0,0,0,1,'h11,0));
    // lone q_last is ignored, arbiter still idle
    tbl.push_back(mkv(0, 0,0,0, 0,0,1, 0,0,0,0,1,'h11,0));
    tbl.push_back(mkv(0, 1,'h30,0, 0,0,0, 1,0,0,0,1,'h30,0));
    tbl.push_back(mkv(0, 0,0,0, 0,0,0, 0,0,1,0,1,'h30,1));
    tbl.push_back(mkv(0, 0,0,0, 0,0,0, 0,0,0,0,1,'h30,0));

    #2;
    do_reset(1'b0);
    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset(1'b0);
      step(tbl[i]);
    end

    // starvation cap: T streams, Q waits
    do_reset(1'b0);
    tg = 0; qg = 0; first_q = -1; t_before = 0; t_resume = -1;
    for (int i = 0; i < 200 && tg < 40; i++) begin
      v = mks(1, tg, 0, (i >= 1) && (qg < 3), 100 + qg, qg == 2);
      step(v);
      if (obs_qg) begin
        if (first_q < 0) first_q = i;
        qg++;
      end
      if (obs_tg) begin
        tg++;
        if (first_q < 0) t_before++;
        else if (t_resume < 0) t_resume = i;
      end
    end
    chk("t3_t_burst", t_before, 16);
    chk("t3_first_q", first_q, 16);
    chk("t3_t_resume", t_resume, 19);
    chk("t3_t_total", tg, 40);

    // hand-over T->Q seen at latency 3
    do_reset(1'b0);
    tgc = 0; qgc = 0; first_trv = -1; first_qrv = -1;
    for (int i = 0; i < 14; i++) begin
      v = mks(tgc < 3, 200 + tgc, tgc == 2,
        (i >= 1) && (qgc < 3), 300 + qgc, qgc == 2);
      step(v);
      if (obs_tg) tgc++;
      if (obs_qg) qgc++;
      if (obs_trv3) begin
        seq3.push_back(1);
        if (first_trv < 0) first_trv = i;
      end
      if (obs_qrv3) begin
        seq3.push_back(2);
        if (first_qrv < 0) first_qrv = i;
      end
    end
    chk("t4_nrv", seq3.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < seq3.size()) chk("t4_order", seq3[k], (k < 3) ? 1 : 2);
    chk("t4_first_t_rv", first_trv, 3);
    chk("t4_first_q_rv", first_qrv, 6);

    // random traffic
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      v = mks($urandom_range(0, 4) != 0, $urandom_range(0, 1023),
        $urandom_range(0, 19) == 0,
        $urandom_range(0, 2) != 0, $urandom_range(0, 1023),
        $urandom_range(0, 9) == 0);
      step(v);
    end

    // reset with reads in flight
    do_reset(1'b0);
    step(mks(1, 'h50, 0, 0, 0, 0));
    step(mks(1, 'h51, 1, 0, 0, 0));
    do_reset(1'b1);
    repeat (5) step(mks(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
      nvec, nbad);
    $finish;
  end

endmodule
